// File: rtl/mm_tile_pkg.sv
// Shared types and constants for the mm_tile systolic matrix-multiply core.
package mm_tile_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, SNAP} compute_state_t;
  typedef enum logic       {EMPTY, SEND}             drain_state_t;

  // Zero-injection cycles needed to push the last k-slice through both skews.
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic logic signed [63:0] sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/mm_tile_core_pe.sv
// Single output-stationary MAC cell: acc += a*b, forwards A right and B down.
// Saturating accumulation when MM_TILE_SATURATE_EN is defined, wrapping otherwise.
module mm_pe
  import mm_tile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]          a_q, b_q;

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = ACC_W'(prod);

`ifdef MM_TILE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));
  logic [ACC_W:0] sum;

  // One guard bit: overflow shows as the top two bits disagreeing.
  assign sum = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};

  always_comb begin
    acc_d = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1])
      acc_d = sum[ACC_W] ? SAT_MIN : SAT_MAX;
  end
`else
  assign acc_d = acc_q + prod_ext;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
      a_q   <= a_i;
      b_q   <= b_i;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/mm_tile_core.sv
// N x N output-stationary systolic matmul core with skewed operand feed and a
// row-major drain buffer. Optional saturation via MM_TILE_SATURATE_EN.
module mm_tile_core
  import mm_tile_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [K_W-1:0]        k_len_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N*DATA_W-1:0]   a_in_i,
  input  logic [N*DATA_W-1:0]   b_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ACC_W-1:0]      out_data_o,
  output logic [$clog2(N)-1:0]  out_row_o,
  output logic [$clog2(N)-1:0]  out_col_o,
  output logic                  out_last_o
);

  localparam int IW = $clog2(N);
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_cycles(N) - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

  compute_state_t cst_q;
  drain_state_t   dst_q;
  logic [K_W-1:0] k_len_q, k_cnt_q;
  logic [FW-1:0]  fl_cnt_q;
  logic           done_q;
  logic [IW-1:0]  row_q, col_q;

  logic accept, adv, drain_hs, drain_last, buf_free, snap_fire;

  logic [N-1:0][DATA_W-1:0]        inj_a, inj_b, a_sk, b_sk;
  logic [N-1:0][N-1:0][DATA_W-1:0] a_w, b_w;
  logic [N-1:0][N-1:0][ACC_W-1:0]  acc, buf_q;
  logic [N-1:0][DATA_W-1:0]        edge_a, edge_b;
  logic                            unused_edge;

  assign accept     = (cst_q == LOAD) && in_valid_i;
  assign adv        = accept || (cst_q == FLUSH);
  assign inj_a      = (cst_q == LOAD) ? a_in_i : '0;
  assign inj_b      = (cst_q == LOAD) ? b_in_i : '0;
  assign drain_last = (row_q == IDX_LAST) && (col_q == IDX_LAST);
  assign drain_hs   = (dst_q == SEND) && out_ready_i;
  // The final drain handshake frees the buffer in the same cycle it empties.
  assign buf_free   = (dst_q == EMPTY) || (drain_hs && drain_last);
  assign snap_fire  = (cst_q == SNAP) && buf_free;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_skew
      if (gi == 0) begin : g_d0
        assign a_sk[gi] = inj_a[gi];
        assign b_sk[gi] = inj_b[gi];
      end else begin : g_dn
        logic [gi-1:0][DATA_W-1:0] a_q, b_q;
        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            a_q <= '0;
            b_q <= '0;
          end else if (adv) begin
            a_q[0] <= inj_a[gi];
            b_q[0] <= inj_b[gi];
            for (int k = 1; k < gi; k++) begin
              a_q[k] <= a_q[k-1];
              b_q[k] <= b_q[k-1];
            end
          end
        end
        assign a_sk[gi] = a_q[gi-1];
        assign b_sk[gi] = b_q[gi-1];
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic [DATA_W-1:0] a_src, b_src;
        if (gj == 0) begin : g_al
          assign a_src = a_sk[gi];
        end else begin : g_an
          assign a_src = a_w[gi][gj-1];
        end
        if (gi == 0) begin : g_bt
          assign b_src = b_sk[gj];
        end else begin : g_bn
          assign b_src = b_w[gi-1][gj];
        end
        mm_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
          .clk_i   (clk_i),
          .reset_i (reset_i),
          .en_i    (adv),
          .clr_i   (snap_fire),
          .a_i     (a_src),
          .b_i     (b_src),
          .a_o     (a_w[gi][gj]),
          .b_o     (b_w[gi][gj]),
          .acc_o   (acc[gi][gj])
        );
      end
      assign edge_a[gi] = a_w[gi][N-1];
      assign edge_b[gi] = b_w[N-1][gi];
    end
  endgenerate

  // Operands leaving the right and bottom edges of the grid go nowhere.
  assign unused_edge = ^{edge_a, edge_b};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cst_q    <= IDLE;
      k_len_q  <= '0;
      k_cnt_q  <= '0;
      fl_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= snap_fire;
      case (cst_q)
        IDLE: if (start_i) begin
          k_len_q  <= k_len_i;
          k_cnt_q  <= '0;
          fl_cnt_q <= '0;
          cst_q    <= (k_len_i == '0) ? FLUSH : LOAD;
        end
        LOAD: if (accept) begin
          k_cnt_q <= k_cnt_q + K_W'(1);
          if (k_cnt_q == k_len_q - K_W'(1)) cst_q <= FLUSH;
        end
        FLUSH: begin
          fl_cnt_q <= fl_cnt_q + FW'(1);
          if (fl_cnt_q == FLUSH_LAST) begin
            fl_cnt_q <= '0;
            cst_q    <= SNAP;
          end
        end
        SNAP: if (buf_free) cst_q <= IDLE;
        default: cst_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dst_q <= EMPTY;
      row_q <= '0;
      col_q <= '0;
      buf_q <= '0;
    end else if (snap_fire) begin
      buf_q <= acc;
      dst_q <= SEND;
      row_q <= '0;
      col_q <= '0;
    end else if (drain_hs) begin
      if (drain_last) begin
        dst_q <= EMPTY;
        row_q <= '0;
        col_q <= '0;
      end else if (col_q == IDX_LAST) begin
        col_q <= '0;
        row_q <= row_q + IW'(1);
      end else begin
        col_q <= col_q + IW'(1);
      end
    end
  end

  assign in_ready_o  = (cst_q == LOAD);
  assign busy_o      = (cst_q != IDLE);
  assign done_o      = done_q;
  assign out_valid_o = (dst_q == SEND);
  assign out_data_o  = buf_q[row_q][col_q];
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;
  assign out_last_o  = (dst_q == SEND) && drain_last;

endmodule

// File: tb/tb_mm_tile_core.sv
// Directed + randomized bench for mm_tile_core; checks a 32-bit and a 16-bit instance.
module tb_mm_tile_core;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int KW = 16;
`ifdef MM_TILE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [KW-1:0]   k_len = '0;
  logic [N*DW-1:0] a_in = '0, b_in = '0;

  logic in_ready, busy, done, out_valid, out_last;
  logic [31:0] out_data;
  logic [0:0]  out_row, out_col;
  logic in_ready16, busy16, done16, out_valid16, out_last16;
  logic [15:0] out_data16;
  logic [0:0]  out_row16, out_col16;

  mm_tile_core #(.N(N), .DATA_W(DW), .ACC_W(32), .K_W(KW)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .k_len_i(k_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .a_in_i(a_in), .b_in_i(b_in),
    .busy_o(busy), .done_o(done), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_row_o(out_row), .out_col_o(out_col), .out_last_o(out_last));

  mm_tile_core #(.N(N), .DATA_W(DW), .ACC_W(16), .K_W(KW)) dut16 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .k_len_i(k_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready16), .a_in_i(a_in), .b_in_i(b_in),
    .busy_o(busy16), .done_o(done16), .out_valid_o(out_valid16), .out_ready_i(out_ready),
    .out_data_o(out_data16), .out_row_o(out_row16), .out_col_o(out_col16), .out_last_o(out_last16));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0, fails = 0, done_cnt = 0;
  longint A[N][64];
  longint B[64][N];

  typedef struct { longint d; int r; int c; bit l; int cy; } cap_t;
  typedef struct { longint d; longint d16; int r; int c; bit l; } exp_t;
  cap_t cq[$], cq16[$];
  exp_t eq[$];
  int   cyq[$];

  always @(negedge clk) begin : collect
    cap_t c;
    if (!reset) begin
      if (out_valid && out_ready) begin
        c.d = longint'($signed(out_data)); c.r = int'(out_row); c.c = int'(out_col);
        c.l = out_last; c.cy = cyc;
        cq.push_back(c);
      end
      if (out_valid16 && out_ready) begin
        c.d = longint'($signed(out_data16)); c.r = int'(out_row16); c.c = int'(out_col16);
        c.l = out_last16; c.cy = cyc;
        cq16.push_back(c);
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: straight sum over k of A[i][k]*B[k][j], clamped or wrapped every step.
  function automatic longint model(int i, int j, int k, int w, bit sat);
    longint acc = 0;
    longint lo = -(longint'(1) << (w - 1));
    longint hi = -lo - 1;
    longint m  = longint'(1) << w;
    for (int kk = 0; kk < k; kk++) begin
      acc += A[i][kk] * B[kk][j];
      if (sat) begin
        if (acc > hi) acc = hi;
        else if (acc < lo) acc = lo;
      end else begin
        acc = (acc - lo) % m;
        if (acc < 0) acc += m;
        acc = acc + lo;
      end
    end
    return acc;
  endfunction

  task automatic push_expected(input int k);
    exp_t e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e.d = model(r, c, k, 32, 1'b0); e.d16 = model(r, c, k, 16, SAT);
        e.r = r; e.c = c; e.l = (r == N - 1) && (c == N - 1);
        eq.push_back(e);
      end
  endtask

  task automatic start_op(input int k);
    int t = 0;
    while (busy && t < 2000) begin @(posedge clk); #1; t++; end
    chk("start_idle", busy, 0);
    start = 1'b1; k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input int k, input int maxgap, output int last_cyc);
    bit ok;
    int t, cnow;
    last_cyc = 0;
    for (int kk = 0; kk < k; kk++) begin
      int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      if (maxgap < 0) gap = -maxgap;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      for (int i = 0; i < N; i++) begin
        a_in[i*DW +: DW] = A[i][kk][DW-1:0];
        b_in[i*DW +: DW] = B[kk][i][DW-1:0];
      end
      in_valid = 1'b1;
      t = 0; ok = 1'b0;
      while (!ok && t < 1000) begin
        ok = in_ready; cnow = cyc;
        @(posedge clk); #1; t++;
      end
      chk("beat_accept", ok, 1);
      last_cyc = cnow;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while ((cq.size() < n || cq16.size() < n) && t < 3000) begin @(posedge clk); #1; t++; end
    chk("words_arrived", (cq.size() >= n && cq16.size() >= n), 1);
  endtask

  task automatic check_words(input string tag, input int n);
    cap_t c, c16;
    exp_t e;
    wait_words(n);
    cyq.delete();
    if (cq.size() < n || cq16.size() < n || eq.size() < n) return;
    for (int idx = 0; idx < n; idx++) begin
      c = cq.pop_front(); c16 = cq16.pop_front(); e = eq.pop_front();
      cyq.push_back(c.cy);
      chk($sformatf("%s_data%0d", tag, idx), c.d, e.d);
      chk($sformatf("%s_row%0d", tag, idx), c.r, e.r);
      chk($sformatf("%s_col%0d", tag, idx), c.c, e.c);
      chk($sformatf("%s_last%0d", tag, idx), c.l, e.l);
      chk($sformatf("%s_data16_%0d", tag, idx), c16.d, e.d16);
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
    chk("valid_seen", out_valid, 1);
  endtask

  task automatic set_t1();
    A[0][0] = 1; A[1][0] = 3; A[0][1] = 2; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
  endtask

  task automatic set_const(input int k, input longint v);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin A[i][kk] = v; B[kk][i] = v; end
  endtask

  initial begin
    int lb, d0, k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_in_ready16", in_ready16, 0);
    chk("rst_done16", done16, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_out_valid", out_valid, 0);

    // Basic 2x2 product, out_ready high
    set_t1(); push_expected(2);
    d0 = done_cnt;
    start_op(2);
    send_beats(2, 0, lb);
    check_words("t1", 4);
    chk("t1_latency", cyq[0] - lb, 2 * N + 1);
    chk("t1_consecutive", cyq[3] - cyq[0], 3);
    repeat (3) @(posedge clk); #1;
    chk("t1_done_pulses", done_cnt - d0, 1);

    // Input gaps and downstream stall on the first word
    out_ready = 1'b0;
    set_t1(); push_expected(2);
    start_op(2);
    send_beats(2, -3, lb);
    wait_valid();
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall_valid%0d", s), out_valid, 1);
      chk($sformatf("stall_data%0d", s), out_data, 19);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check_words("stall", 4);

    // Most-negative operands, then an empty inner dimension
    set_const(4, -128); push_expected(4);
    start_op(4); send_beats(4, 0, lb);
    check_words("neg", 4);
    push_expected(0);
    start_op(0);
    check_words("k0", 4);

    // Second operation issued while the first drain is stalled
    out_ready = 1'b0;
    set_t1(); push_expected(2);
    start_op(2); send_beats(2, 0, lb);
    wait_valid();
    set_const(1, 1); push_expected(1);
    start_op(1); send_beats(1, 0, lb);
    repeat (8) @(posedge clk); #1;
    chk("ovl_snap_hold_busy", busy, 1);
    chk("ovl_hold_valid", out_valid, 1);
    chk("ovl_hold_data", out_data, 19);
    out_ready = 1'b1;
    check_words("ovl", 8);
    chk("ovl_back_to_back", cyq[4] - cyq[3], 1);

    // Reset in the middle of LOAD, then a clean run
    set_t1();
    start_op(2);
    send_beats(1, 0, lb);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    reset = 1'b0;
    cq.delete(); cq16.delete();
    repeat (10) @(posedge clk); #1;
    chk("abort_no_output", cq.size(), 0);
    chk("abort_valid_idle", out_valid, 0);
    push_expected(2);
    start_op(2); send_beats(2, 0, lb);
    check_words("post_rst", 4);

    // 16-bit accumulator overflow
    set_const(3, 127); push_expected(3);
    start_op(3); send_beats(3, 0, lb);
    wait_words(1);
    if (cq16.size() > 0) chk("acc16_overflow", cq16[0].d, SAT ? 32767 : -17149);
    check_words("ovf", 4);

    // Randomized operands and inner dimensions
    for (int op = 0; op < 6; op++) begin
      k = int'($urandom_range(1, 6));
      for (int kk = 0; kk < k; kk++)
        for (int i = 0; i < N; i++) begin
          A[i][kk] = longint'($urandom_range(0, 255)) - 128;
          B[kk][i] = longint'($urandom_range(0, 255)) - 128;
        end
      push_expected(k);
      start_op(k); send_beats(k, 2, lb);
      check_words($sformatf("rnd%0d", op), 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mm_tile_core.md
Name: mm_tile_core

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply core. It computes C = A x B with A of size N x K and B of size K x N, using signed DATA_W operands and ACC_W accumulators.
- Operands stream in one k-slice per beat through a valid/ready handshake.
- Results are snapshotted into a drain buffer and streamed out row-major over a valid/ready handshake. The next operation may load while the previous result drains.
- Sits between the operand fetch/DMA front-end and the result writeback to memory.

Parameters:
- N, 2, tile dimension (rows = columns of PE array), >= 2
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator and result width
- K_W, 16, width of k_len

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  begin operation; sampled only in IDLE
- k_len  input  K_W  unsigned inner dimension K; sampled with start
- in_valid  input  1  operand beat valid
- in_ready  output  1  core accepts beat
- a_in  input  N*DATA_W  column k of A; slice i = A[i][k]
- b_in  input  N*DATA_W  row k of B; slice j = B[k][j]
- busy  output  1  compute FSM not IDLE
- done  output  1  one-cycle pulse on snapshot
- out_valid  output  1  result word valid
- out_ready  input  1  downstream accepts result
- out_data  output  ACC_W  C[row][col]
- out_row  output  $clog2(N)  row index
- out_col  output  $clog2(N)  column index
- out_last  output  1  high with final element C[N-1][N-1]

Behaviour:
- Reset: all outputs 0, both FSMs idle, accumulators, skew registers and drain buffer cleared. Reset mid-operation aborts everything; no partial output is produced.
- Compute FSM states: IDLE, LOAD, FLUSH, SNAP.
  - IDLE: start=1 latches k_len. Go to LOAD, or go to FLUSH if k_len=0. start outside IDLE is ignored.
  - LOAD: in_ready=1. Array and skew chain advance only on an accepted beat (in_valid & in_ready); otherwise they hold. After the k_len-th accepted beat, go to FLUSH.
  - FLUSH: zeros are injected and the array advances every cycle for exactly 2N-1 cycles, then go to SNAP.
  - SNAP: if the drain buffer is empty, copy all accumulators into it, clear the accumulators, pulse done, and go to IDLE. If the buffer is occupied, hold SNAP with the array frozen.
- Skew: row i of A and column j of B are delayed by i and j stages respectively. PE(i,j) passes A right and B down.
- Arithmetic:
  - Each PE computes acc += sext(a)*sext(b); the product is 2*DATA_W bits, sign-extended to ACC_W.
  - Wraps modulo 2^ACC_W by default.
  - k_len=0 produces an all-zero C.
- Drain FSM states: EMPTY, SEND.
  - Snapshot moves EMPTY to SEND with index (0,0).
  - In SEND, out_valid=1, and out_data/out_row/out_col stay stable until out_ready.
  - On each handshake the index advances row-major. out_last is high at (N-1,N-1); that handshake returns the FSM to EMPTY.
- Latency: with out_ready=1 and the buffer empty, the first out_valid occurs 2N+1 cycles after the cycle of the last accepted beat. There are then N*N consecutive words.
- Overlap: a new start is accepted while draining. Its SNAP waits for the buffer to empty. Results never mix between operations.
- Simultaneous events:
  - Final drain handshake and SNAP in the same cycle: the buffer is reloaded that cycle, and out_valid remains 1 with index (0,0) next cycle.

Optional Feature:
- Macro: MM_TILE_SATURATE_EN.
- When defined, each PE accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Once saturated, an accumulator can still move back toward zero.
- When undefined, accumulation wraps modulo 2^ACC_W.

Decomposition:
- Package mm_tile_pkg holds:
  - compute_state_t {IDLE, LOAD, FLUSH, SNAP}
  - drain_state_t {EMPTY, SEND}
  - function flush_cycles(N) = 2N-1
  - saturation min/max constant functions of ACC_W
- One sub-module, mm_pe: a single MAC cell with enable, clear, A/B pass-through registers and the saturation option.
- mm_tile_core instantiates an N x N grid of mm_pe plus the skew registers, both FSMs and the drain buffer.

Test Plan:
- N=2, k_len=2; beats a=(1,3),b=(5,6) then a=(2,4),b=(7,8); out_ready=1 -> outputs 19,22,43,50 at (0,0),(0,1),(1,0),(1,1); out_last only on 50; done single pulse; first out_valid 5 cycles after the last beat.
- Same operation with in_valid low for 3 cycles between beats, and out_ready low for 5 cycles at the first word -> out_data held at 19 with out_valid=1 while stalled; identical results.
- k_len=4, all a=b=-128 -> all four outputs 65536; k_len=0 -> four outputs of 0.
- Second start (k_len=1, a=b=(1,1)) issued during the drain of the first operation, with out_ready held low -> SNAP holds; after the first drain, outputs 1,1,1,1; no mixing of results.
- Reset asserted mid-LOAD of the first operation, then a fresh operation from the first test -> out_valid 0 until the new result; outputs 19,22,43,50.
- ACC_W=16, k_len=3, a=b=127 (sum 48387): with MM_TILE_SATURATE_EN -> 32767; without -> -17149.
